br_checkpoint_stack: RTL and testbench

- Storage end of the branch-mask protocol. The branch mask controller allocates one-hot branch bits and broadcasts resolve bits; this block holds one checkpoint per bit.
- On dispatch of a branch, captures a recovery snapshot (map-table/free-list state, packed) into the slot named by the allocated bit.
- On a wrong resolve, plays back that slot's snapshot to the rename stage and frees every younger slot.
- On a correct resolve, frees the slot.

---
 rtl/br_checkpoint_stack_pkg.sv | 27 ++
 rtl/br_checkpoint_stack_onehot_idx_dec.sv | 22 ++
 rtl/sys_defs.svh | 14 +
 rtl/br_checkpoint_stack.sv | 111 +++++++++++
 tb/tb_br_checkpoint_stack.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/br_checkpoint_stack_pkg.sv
// Shared types and helpers for the branch checkpoint stack.
`include "sys_defs.svh"

package br_checkpoint_stack_pkg;

    localparam int unsigned BR_STATE_W = `BR_STATE_W;

    typedef enum logic [1:0] {
        RES_NONE    = 2'd0,
        RES_CORRECT = 2'd1,
        RES_WRONG   = 2'd2
    } res_kind_e;

    // Any encoding other than WRONG/CORRECT is treated as "no resolve".
    function automatic res_kind_e res_kind(input logic [BR_STATE_W-1:0] st);
        case (st)
            `BR_PR_WRONG:   return RES_WRONG;
            `BR_PR_CORRECT: return RES_CORRECT;
            default:        return RES_NONE;
        endcase
    endfunction

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/br_checkpoint_stack_onehot_idx_dec.sv
// One-hot to binary index decoder with a one-hot validity flag.
module onehot_idx_dec
    import br_checkpoint_stack_pkg::*;
#(
    parameter int unsigned N  = 5,
    parameter int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  i_vec,
    output logic [IW-1:0] o_idx_c,
    output logic          o_onehot_c
);

    always_comb begin
        o_idx_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (i_vec[i]) o_idx_c = IW'(i);
        end
    end

    assign o_onehot_c = (i_vec != '0) && ((i_vec & (i_vec - N'(1))) == '0);

endmodule

// File: rtl/sys_defs.svh
// Shared branch-mask protocol definitions used by the rename/ROB/checkpoint blocks.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH

`define SD #1

`define BR_MASK_W     5
`define BR_STATE_W    2
`define BR_PR_NONE    2'b00
`define BR_PR_CORRECT 2'b01
`define BR_PR_WRONG   2'b10
`define BR_SNAP_W     64

`endif

// File: rtl/br_checkpoint_stack.sv
// Per-branch-bit recovery checkpoints: capture on dispatch, replay on mispredict, free on resolve.
`include "sys_defs.svh"

module br_checkpoint_stack
    import br_checkpoint_stack_pkg::*;
#(
    parameter int unsigned SNAP_W = `BR_SNAP_W,
    parameter int unsigned NSLOT  = `BR_MASK_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   is_br_i,
    input  logic [NSLOT-1:0]       br_alloc_bit_i,
    input  logic [SNAP_W-1:0]      snapshot_i,
    input  logic [`BR_STATE_W-1:0] br_state_i,
    input  logic [NSLOT-1:0]       br_bit_i,
    input  logic [NSLOT-1:0]       br_dep_mask_i,
    output logic                   rc_valid_o,
    output logic [SNAP_W-1:0]      rc_snapshot_o,
    output logic [NSLOT-1:0]       valid_mask_o,
    output logic                   full_o,
    output logic                   err_o
);

    localparam int unsigned IW = idx_w(NSLOT);

    logic [NSLOT-1:0]  r_valid;
    logic [SNAP_W-1:0] r_data [NSLOT];
    logic              r_rc_valid;
    logic [SNAP_W-1:0] r_rc_snap;
    logic              r_err;

    logic [IW-1:0]     w_alloc_idx;
    logic              w_alloc_oh;
    logic [IW-1:0]     w_res_idx;
    logic              w_res_oh;
    res_kind_e         w_kind;
    logic              w_wrong;
    logic              w_correct;
    logic              w_res_ok;
    logic              w_alloc_req;
    logic              w_freed_same;
    logic              w_alloc_ok;
    logic              w_recover;
    logic              w_err_now;
    logic [NSLOT-1:0]  w_valid_nxt;

    onehot_idx_dec #(.N(NSLOT), .IW(IW)) u_alloc_dec (
        .i_vec      (br_alloc_bit_i),
        .o_idx_c    (w_alloc_idx),
        .o_onehot_c (w_alloc_oh)
    );

    onehot_idx_dec #(.N(NSLOT), .IW(IW)) u_res_dec (
        .i_vec      (br_bit_i),
        .o_idx_c    (w_res_idx),
        .o_onehot_c (w_res_oh)
    );

    assign w_kind    = res_kind(br_state_i);
    assign w_wrong   = (w_kind == RES_WRONG);
    assign w_correct = (w_kind == RES_CORRECT);

    // A resolve only acts on a single, currently occupied slot.
    assign w_res_ok     = (w_wrong || w_correct) && w_res_oh && r_valid[w_res_idx];
    assign w_recover    = w_wrong && w_res_ok;
    assign w_alloc_req  = is_br_i && !w_wrong;
    assign w_freed_same = w_correct && w_res_ok && (w_res_idx == w_alloc_idx);
    assign w_alloc_ok   = w_alloc_req && w_alloc_oh && (!r_valid[w_alloc_idx] || w_freed_same);

    assign w_err_now = (is_br_i && !w_alloc_oh)
                     || (w_alloc_req && w_alloc_oh && !w_alloc_ok)
                     || ((w_wrong || w_correct) && !w_res_ok);

    // Mispredict flush wins over everything; otherwise free-then-allocate.
    always_comb begin
        w_valid_nxt = r_valid;
        if (w_recover) begin
            w_valid_nxt = r_valid & br_dep_mask_i;
        end else begin
            if (w_correct && w_res_ok) w_valid_nxt[w_res_idx] = 1'b0;
            if (w_alloc_ok)            w_valid_nxt[w_alloc_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= '0;
            r_rc_valid <= 1'b0;
            r_rc_snap  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_valid    <= w_valid_nxt;
            r_rc_valid <= w_recover;
            if (w_recover) r_rc_snap <= r_data[w_res_idx];
            r_err      <= r_err | w_err_now;
        end
    end

    // Slot payload needs no reset; a slot is only read while its valid bit is set.
    always_ff @(posedge clk) begin
        if (w_alloc_ok) r_data[w_alloc_idx] <= snapshot_i;
    end

    assign rc_valid_o    = r_rc_valid;
    assign rc_snapshot_o = r_rc_snap;
    assign valid_mask_o  = r_valid;
    assign full_o        = &r_valid;
    assign err_o         = r_err;

endmodule

// File: tb/tb_br_checkpoint_stack.sv
// Directed vector table plus randomized run against a mask-level reference model.
`include "sys_defs.svh"

module tb_br_checkpoint_stack;

    localparam int unsigned N  = 5;
    localparam int unsigned SW = 64;
    localparam logic [1:0] ST_N = `BR_PR_NONE;
    localparam logic [1:0] ST_C = `BR_PR_CORRECT;
    localparam logic [1:0] ST_W = `BR_PR_WRONG;

    logic          clk = 1'b0;
    logic          rst;
    logic          is_br;
    logic [N-1:0]  alloc_bit;
    logic [SW-1:0] snap;
    logic [1:0]    br_state;
    logic [N-1:0]  br_bit;
    logic [N-1:0]  dep_mask;
    logic          rc_valid;
    logic [SW-1:0] rc_snap;
    logic [N-1:0]  valid_mask;
    logic          full;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    br_checkpoint_stack #(.SNAP_W(SW), .NSLOT(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .is_br_i       (is_br),
        .br_alloc_bit_i(alloc_bit),
        .snapshot_i    (snap),
        .br_state_i    (br_state),
        .br_bit_i      (br_bit),
        .br_dep_mask_i (dep_mask),
        .rc_valid_o    (rc_valid),
        .rc_snapshot_o (rc_snap),
        .valid_mask_o  (valid_mask),
        .full_o        (full),
        .err_o         (err)
    );

    typedef struct {
        logic          rst;
        logic          is_br;
        logic [N-1:0]  alloc;
        logic [SW-1:0] snap;
        logic [1:0]    st;
        logic [N-1:0]  br_bit;
        logic [N-1:0]  dep;
        logic [N-1:0]  e_vm;
        logic          e_rcv;
        logic [SW-1:0] e_rcs;
        logic          e_full;
        logic          e_err;
    } vec_t;

    vec_t tbl[26];

    // Reference model state
    logic          m_valid [N];
    logic [SW-1:0] m_data  [N];
    logic          m_rcv;
    logic [SW-1:0] m_rcs;
    logic          m_err;

    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic b, input logic [N-1:0] a, input logic [SW-1:0] s,
                         input logic [1:0] st, input logic [N-1:0] bb, input logic [N-1:0] d);
        @(negedge clk);
        rst = r; is_br = b; alloc_bit = a; snap = s;
        br_state = st; br_bit = bb; dep_mask = d;
        @(posedge clk);
        #1;
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < int'(N); i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [N-1:0] m_mask();
        logic [N-1:0] r = '0;
        for (int i = 0; i < int'(N); i++) r[i] = m_valid[i];
        return r;
    endfunction

    // Applies one cycle of the protocol rules to the model, using pre-edge state.
    task automatic model_step(input logic r, input logic b, input logic [N-1:0] a, input logic [SW-1:0] s,
                              input logic [1:0] st, input logic [N-1:0] bb, input logic [N-1:0] d);
        logic wrong, correct, res_ok, a_oh, alloc_req, freed, alloc_ok;
        logic [N-1:0] vm;
        if (r) begin
            for (int i = 0; i < int'(N); i++) m_valid[i] = 1'b0;
            m_rcv = 1'b0; m_rcs = '0; m_err = 1'b0;
            return;
        end
        vm        = m_mask();
        wrong     = (st == ST_W);
        correct   = (st == ST_C);
        res_ok    = (wrong || correct) && ($countones(bb) == 1) && ((vm & bb) != '0);
        a_oh      = ($countones(a) == 1);
        alloc_req = b && !wrong;
        freed     = correct && res_ok && (bb == a);
        alloc_ok  = alloc_req && a_oh && (((vm & a) == '0) || freed);
        if ((b && !a_oh) || (alloc_req && a_oh && !alloc_ok) || ((wrong || correct) && !res_ok))
            m_err = 1'b1;
        m_rcv = wrong && res_ok;
        if (m_rcv) m_rcs = m_data[idx_of(bb)];
        if (wrong && res_ok) begin
            vm = vm & d;
        end else begin
            if (correct && res_ok) vm = vm & ~bb;
            if (alloc_ok) begin
                vm = vm | a;
                m_data[idx_of(a)] = s;
            end
        end
        for (int i = 0; i < int'(N); i++) m_valid[i] = vm[i];
    endtask

    initial begin
        logic [N-1:0] vm, pick;
        logic r, b;
        logic [N-1:0] a, bb, d;
        logic [SW-1:0] s;
        logic [1:0] st;
        int k;

        rst = 1'b1; is_br = 1'b0; alloc_bit = '0; snap = '0;
        br_state = ST_N; br_bit = '0; dep_mask = '0;

        //            rst   br    alloc     snap   st    bit       dep       vm        rcv   rcs    full  err
        tbl[0]  = '{1'b1, 1'b0, 5'b00000, 64'h0,  ST_N, 5'b00000, 5'b00000, 5'b00000, 1'b0, 64'h0,  1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 5'b00001, 64'hA,  ST_N, 5'b00000, 5'b00000, 5'b00001, 1'b0, 64'h0,  1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 5'b00010, 64'hB,  ST_N, 5'b00000, 5'b00000, 5'b00011, 1'b0, 64'h0,  1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 5'b00100, 64'hC,  ST_N, 5'b00000, 5'b00000, 5'b00111, 1'b0, 64'h0,  1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 5'b00000, 64'h0,  ST_W, 5'b00010, 5'b00001, 5'b00001, 1'b1, 64'hB,  1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 5'b00000, 64'h0,  ST_N, 5'b00000, 5'b00000, 5'b00001, 1'b0, 64'hB,  1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 5'b00001, 64'hD,  ST_C, 5'b00001, 5'b00000, 5'b00001, 1'b0, 64'hB,  1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 5'b00000, 64'h0,  ST_W, 5'b00001, 5'b00000, 5'b00000, 1'b1, 64'hD,  1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 5'b00001, 64'hE,  ST_N, 5'b00000, 5'b00000, 5'b00001, 1'b0, 64'hD,  1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 5'b00010, 64'hF,  ST_N, 5'b00000, 5'b00000, 5'b00011, 1'b0, 64'hD,  1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 5'b00100, 64'h10, ST_N, 5'b00000, 5'b00000, 5'b00111, 1'b0, 64'hD,  1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 5'b01000, 64'h11, ST_N, 5'b00000, 5'b00000, 5'b01111, 1'b0, 64'hD,  1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 5'b10000, 64'h12, ST_N, 5'b00000, 5'b00000, 5'b11111, 1'b0, 64'hD,  1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 5'b00100, 64'h99, ST_N, 5'b00000, 5'b00000, 5'b11111, 1'b0, 64'hD,  1'b1, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 5'b00000, 64'h0,  ST_W, 5'b00100, 5'b00011, 5'b00011, 1'b1, 64'h10, 1'b0, 1'b1};
        tbl[15] = '{1'b1, 1'b0, 5'b00000, 64'h0,  ST_N, 5'b00000, 5'b00000, 5'b00000, 1'b0, 64'h0,  1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 5'b00001, 64'hA,  ST_N, 5'b00000, 5'b00000, 5'b00001, 1'b0, 64'h0,  1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 5'b00010, 64'h55, ST_W, 5'b00001, 5'b00000, 5'b00000, 1'b1, 64'hA,  1'b0, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 5'b00000, 64'h0,  ST_N, 5'b00000, 5'b00000, 5'b00000, 1'b0, 64'h0,  1'b0, 1'b0};
        tbl[19] = '{1'b0, 1'b1, 5'b00001, 64'hA1, ST_N, 5'b00000, 5'b00000, 5'b00001, 1'b0, 64'h0,  1'b0, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 5'b00000, 64'h0,  ST_C, 5'b00010, 5'b00000, 5'b00001, 1'b0, 64'h0,  1'b0, 1'b1};
        tbl[21] = '{1'b1, 1'b0, 5'b00000, 64'h0,  ST_N, 5'b00000, 5'b00000, 5'b00000, 1'b0, 64'h0,  1'b0, 1'b0};
        tbl[22] = '{1'b0, 1'b1, 5'b00001, 64'hA2, ST_N, 5'b00000, 5'b00000, 5'b00001, 1'b0, 64'h0,  1'b0, 1'b0};
        tbl[23] = '{1'b0, 1'b0, 5'b00000, 64'h0,  ST_C, 5'b00011, 5'b00000, 5'b00001, 1'b0, 64'h0,  1'b0, 1'b1};
        tbl[24] = '{1'b0, 1'b0, 5'b00000, 64'h0,  ST_C, 5'b00001, 5'b00000, 5'b00000, 1'b0, 64'h0,  1'b0, 1'b1};
        tbl[25] = '{1'b0, 1'b0, 5'b00000, 64'h0,  ST_W, 5'b00001, 5'b00000, 5'b00000, 1'b0, 64'h0,  1'b0, 1'b1};

        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].rst, tbl[i].is_br, tbl[i].alloc, tbl[i].snap, tbl[i].st, tbl[i].br_bit, tbl[i].dep);
            check($sformatf("vec%0d_valid_mask", i), SW'(valid_mask), SW'(tbl[i].e_vm));
            check($sformatf("vec%0d_rc_valid", i),   SW'(rc_valid),   SW'(tbl[i].e_rcv));
            check($sformatf("vec%0d_rc_snapshot", i), rc_snap,        tbl[i].e_rcs);
            check($sformatf("vec%0d_full", i),       SW'(full),       SW'(tbl[i].e_full));
            check($sformatf("vec%0d_err", i),        SW'(err),        SW'(tbl[i].e_err));
        end

        // Randomized phase: start from a clean reset so the model and DUT agree.
        drive(1'b1, 1'b0, '0, '0, ST_N, '0, '0);
        model_step(1'b1, 1'b0, '0, '0, ST_N, '0, '0);
        for (int c = 0; c < 600; c++) begin
            vm = m_mask();
            r  = ($urandom_range(0, 79) == 0);
            k  = $urandom_range(0, 9);
            st = (k < 6) ? ST_N : ((k < 8) ? ST_C : ST_W);
            if (vm != '0 && $urandom_range(0, 15) != 0) begin
                do pick = N'(1) << $urandom_range(0, N - 1); while ((pick & vm) == '0);
                bb = pick;
            end else begin
                bb = N'($urandom);
            end
            d = N'($urandom) & vm & ~bb;
            b = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) begin
                a = N'($urandom);
            end else if (vm != '1 && $urandom_range(0, 7) != 0) begin
                do pick = N'(1) << $urandom_range(0, N - 1); while ((pick & vm) != '0);
                a = pick;
            end else begin
                a = N'(1) << $urandom_range(0, N - 1);
            end
            s = {$urandom, $urandom};
            drive(r, b, a, s, st, bb, d);
            model_step(r, b, a, s, st, bb, d);
            check("rand_valid_mask", SW'(valid_mask), SW'(m_mask()));
            check("rand_rc_valid",   SW'(rc_valid),   SW'(m_rcv));
            check("rand_rc_snapshot", rc_snap,        m_rcs);
            check("rand_full",       SW'(full),       SW'(&m_mask()));
            check("rand_err",        SW'(err),        SW'(m_err));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
